// File: rtl/hrm_outbox_uart_if.sv
// Outbox write channel between the control unit (master) and the outbox/UART block (slave).
interface hrm_outbox_uart_if #(
  parameter int unsigned DEPTH_LOG2 = 4
) ();
  logic                wO;
  logic [7:0]          i_data;
  logic                outFull;
  logic                o_empty;
  logic [DEPTH_LOG2:0] o_count;
  logic                o_ovf;

  modport master (
    output wO,
    output i_data,
    input  outFull,
    input  o_empty,
    input  o_count,
    input  o_ovf
  );

  modport slave (
    input  wO,
    input  i_data,
    output outFull,
    output o_empty,
    output o_count,
    output o_ovf
  );
endinterface

// File: rtl/hrm_outbox_uart.sv
// CPU outbox consumer: buffers outbox writes in a circular FIFO and drains them
// over an 8N1 UART transmit line, LSB first, with back-to-back frames contiguous.
module hrm_outbox_uart #(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic                    clk,
  input  logic                    i_rst,
  hrm_outbox_uart_if.slave        outbox,
  output logic                    tx,
  output logic                    tx_busy
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned BcntW = $clog2(CLKS_PER_BIT);
  localparam logic [BcntW-1:0] BcntLast = BcntW'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0] CntFull = (DEPTH_LOG2 + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wptr_q;
  logic [DEPTH_LOG2-1:0] rptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  ovf_q;

  state_e                state_q;
  logic [BcntW-1:0]      bcnt_q;
  logic [2:0]            bidx_q;
  logic [7:0]            shift_q;
  logic                  tx_q;

  logic full;
  logic empty;
  logic wr_acc;
  logic bit_end;
  logic pop;

  // Full/empty come from the registered count, so a same-cycle pop never rescues a full write.
  always_comb begin
    full    = (count_q == CntFull);
    empty   = (count_q == '0);
    wr_acc  = outbox.wO && !full;
    bit_end = (bcnt_q == BcntLast);
    pop     = !empty && ((state_q == StIdle) || ((state_q == StStop) && bit_end));
  end

  // Byte storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wptr_q] <= outbox.i_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr_q <= wptr_q + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + DEPTH_LOG2'(1);
      end
      if (wr_acc && !pop) begin
        count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
      end else if (!wr_acc && pop) begin
        count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
      end
      if (outbox.wO && full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // UART framing FSM; tx is registered from the state selected at the previous edge.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      bcnt_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rptr_q];
            bcnt_q  <= '0;
            state_q <= StStart;
          end
        end
        StStart: begin
          tx_q <= 1'b0;
          if (bit_end) begin
            bcnt_q  <= '0;
            bidx_q  <= '0;
            state_q <= StData;
          end else begin
            bcnt_q <= bcnt_q + BcntW'(1);
          end
        end
        StData: begin
          tx_q <= shift_q[bidx_q];
          if (bit_end) begin
            bcnt_q <= '0;
            if (bidx_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bidx_q <= bidx_q + 3'd1;
            end
          end else begin
            bcnt_q <= bcnt_q + BcntW'(1);
          end
        end
        StStop: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            bcnt_q <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              shift_q <= mem_q[rptr_q];
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            bcnt_q <= bcnt_q + BcntW'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign outbox.outFull = full;
  assign outbox.o_empty = empty;
  assign outbox.o_count = count_q;
  assign outbox.o_ovf   = ovf_q;
  assign tx             = tx_q;
  assign tx_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_hrm_outbox_uart.sv
// Bench for hrm_outbox_uart: two instances (16-deep/4 clk-per-bit and 4-deep/8 clk-per-bit),
// a UART line decoder per instance checking bytes against a scoreboard queue.
module tb_hrm_outbox_uart;

  localparam int ACpb = 4;
  localparam int BCpb = 8;

  logic clk = 1'b0;
  logic i_rst = 1'b0;
  logic tx_a, busy_a, tx_b, busy_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int starts[2];
  int frames[2];
  int start_cyc_a[$];

  hrm_outbox_uart_if #(.DEPTH_LOG2(4)) ifa ();
  hrm_outbox_uart_if #(.DEPTH_LOG2(2)) ifb ();

  hrm_outbox_uart #(.DEPTH_LOG2(4), .CLKS_PER_BIT(ACpb)) dut_a (
    .clk     (clk),
    .i_rst   (i_rst),
    .outbox  (ifa),
    .tx      (tx_a),
    .tx_busy (busy_a)
  );

  hrm_outbox_uart #(.DEPTH_LOG2(2), .CLKS_PER_BIT(BCpb)) dut_b (
    .clk     (clk),
    .i_rst   (i_rst),
    .outbox  (ifb),
    .tx      (tx_b),
    .tx_busy (busy_b)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line level k cycles after the falling edge of a start bit.
  function automatic logic line_bit(input int k, input logic [7:0] b, input int cpb);
    int j;
    j = k / cpb;
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    return 1'b1;
  endfunction

  // Decodes frames by mid-bit sampling and compares each byte with the scoreboard.
  task automatic monitor(input bit sel);
    int         cpb;
    bit         busy;
    int         k;
    logic [7:0] sh;
    logic       line;
    cpb  = sel ? BCpb : ACpb;
    busy = 1'b0;
    k    = 0;
    sh   = '0;
    forever begin
      @(negedge clk);
      line = sel ? tx_b : tx_a;
      if (i_rst) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          k++;
        end else if (!line) begin
          busy = 1'b1;
          k    = 0;
          starts[sel]++;
          if (!sel) start_cyc_a.push_back(cyc);
        end
        if (busy) begin
          if (k == cpb / 2) check_eq(sel ? "start_b" : "start_a", line, 1'b0);
          for (int j = 1; j <= 8; j++) begin
            if (k == j * cpb + cpb / 2) sh[j-1] = line;
          end
          if (k == 9 * cpb + cpb / 2) begin
            check_eq(sel ? "stop_b" : "stop_a", line, 1'b1);
            if (sel) begin
              check_eq("sb_pending_b", q_b.size() != 0, 1'b1);
              if (q_b.size() != 0) check_eq("byte_b", sh, q_b.pop_front());
            end else begin
              check_eq("sb_pending_a", q_a.size() != 0, 1'b1);
              if (q_a.size() != 0) check_eq("byte_a", sh, q_a.pop_front());
            end
            frames[sel]++;
            busy = 1'b0;
          end
        end
      end
    end
  endtask

  // Called at a negedge; holds the write for exactly one rising edge.
  task automatic wr(input bit sel, input logic [7:0] d, input bit push);
    if (sel) begin
      ifb.wO = 1'b1;
      ifb.i_data = d;
      if (push) q_b.push_back(d);
    end else begin
      ifa.wO = 1'b1;
      ifa.i_data = d;
      if (push) q_a.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic drain(input bit sel, input int limit);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (n < limit) begin
      @(negedge clk);
      done = sel ? (q_b.size() == 0 && !busy_b && ifb.o_empty)
                 : (q_a.size() == 0 && !busy_a && ifa.o_empty);
      if (done) break;
      n++;
    end
    check_eq(sel ? "drain_b" : "drain_a", done, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int peak;
    int s0;
    int n;
    logic expl;
    ifa.wO = 1'b0; ifa.i_data = '0;
    ifb.wO = 1'b0; ifb.i_data = '0;
    starts[0] = 0; starts[1] = 0; frames[0] = 0; frames[1] = 0;
    fork
      monitor(1'b0);
      monitor(1'b1);
    join_none

    // Asynchronous reset values before any clock edge.
    #1 i_rst = 1'b1;
    #1;
    check_eq("rst_a", {tx_a, busy_a, ifa.outFull, ifa.o_empty, ifa.o_ovf, ifa.o_count},
             {5'b10010, 5'd0});
    check_eq("rst_b", {tx_b, busy_b, ifb.outFull, ifb.o_empty, ifb.o_ovf, ifb.o_count},
             {5'b10010, 3'd0});
    repeat (3) @(negedge clk);
    i_rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_eq("idle_a", {tx_a, busy_a, ifa.outFull, ifa.o_empty, ifa.o_ovf, ifa.o_count},
               {5'b10010, 5'd0});
      check_eq("idle_b", {tx_b, busy_b, ifb.outFull, ifb.o_empty, ifb.o_ovf, ifb.o_count},
               {5'b10010, 3'd0});
    end

    // Single byte 0x41: exact per-cycle line shape and latency.
    wr(1'b0, 8'h41, 1'b1);
    ifa.wO = 1'b0;
    check_eq("lat_count", ifa.o_count, 1);
    for (int s = 0; s < 44; s++) begin
      expl = (s < 2) ? 1'b1 : line_bit(s - 2, 8'h41, ACpb);
      check_eq("line_41", tx_a, expl);
      if (s == 40) check_eq("busy_last", busy_a, 1'b1);
      if (s == 41) check_eq("busy_done", busy_a, 1'b0);
      @(negedge clk);
    end
    drain(1'b0, 200);

    // Three back-to-back bytes: peak occupancy and contiguous frames.
    start_cyc_a.delete();
    peak = 0;
    wr(1'b0, 8'h00, 1'b1);
    if (ifa.o_count > peak) peak = ifa.o_count;
    wr(1'b0, 8'hFF, 1'b1);
    if (ifa.o_count > peak) peak = ifa.o_count;
    wr(1'b0, 8'h55, 1'b1);
    ifa.wO = 1'b0;
    for (int i = 0; i < 130; i++) begin
      if (ifa.o_count > peak) peak = ifa.o_count;
      @(negedge clk);
    end
    drain(1'b0, 200);
    check_eq("peak_count", peak, 2);
    check_eq("frames3", start_cyc_a.size(), 3);
    if (start_cyc_a.size() >= 3) begin
      check_eq("gap01", start_cyc_a[1] - start_cyc_a[0], 10 * ACpb);
      check_eq("gap12", start_cyc_a[2] - start_cyc_a[1], 10 * ACpb);
    end
    check_eq("empty_end", ifa.o_empty, 1'b1);

    // Fill the 4-deep FIFO, then overflow it.
    check_eq("b_notfull0", ifb.outFull, 1'b0);
    for (int i = 0; i < 5; i++) wr(1'b1, 8'h10 + 8'(i), 1'b1);
    check_eq("b_full", ifb.outFull, 1'b1);
    check_eq("b_count4", ifb.o_count, 4);
    check_eq("b_ovf0", ifb.o_ovf, 1'b0);
    wr(1'b1, 8'h15, 1'b0);
    ifb.wO = 1'b0;
    check_eq("b_ovf1", ifb.o_ovf, 1'b1);
    check_eq("b_count_hold", ifb.o_count, 4);
    drain(1'b1, 1000);
    check_eq("b_ovf_sticky", ifb.o_ovf, 1'b1);

    // Pointer wrap: ten writes, each only while not full.
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check_eq("b_ovf_clr", ifb.o_ovf, 1'b0);
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (ifb.outFull && n < 500) begin
        @(negedge clk);
        n++;
      end
      check_eq("wait_notfull", ifb.outFull, 1'b0);
      wr(1'b1, 8'hA0 + 8'(i), 1'b1);
      ifb.wO = 1'b0;
    end
    drain(1'b1, 2000);
    check_eq("wrap_ovf", ifb.o_ovf, 1'b0);

    // Asynchronous reset in the middle of a data bit.
    for (int i = 0; i < 3; i++) wr(1'b0, 8'h00, 1'b1);
    ifa.wO = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("pre_rst_tx", tx_a, 1'b0);
    check_eq("pre_rst_busy", busy_a, 1'b1);
    #2 i_rst = 1'b1;
    #1;
    check_eq("arst_tx", tx_a, 1'b1);
    check_eq("arst_count", ifa.o_count, 0);
    check_eq("arst_busy", busy_a, 1'b0);
    check_eq("arst_empty", ifa.o_empty, 1'b1);
    q_a.delete();
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    s0 = starts[0];
    repeat (100) @(negedge clk);
    check_eq("post_rst_silent", starts[0], s0);
    check_eq("post_rst_busy", busy_a, 1'b0);
    check_eq("post_rst_count", ifa.o_count, 0);
    wr(1'b0, 8'h5A, 1'b1);
    ifa.wO = 1'b0;
    drain(1'b0, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hrm_outbox_uart.md
Name: hrm_outbox_uart

Overview:
Consumer end of the CPU outbox interface. The control unit asserts wO for one cycle in its OUTBOX state and stalls while outFull is high; this block receives those writes. Accepted bytes are buffered in a small FIFO and drained over a UART transmit line (8N1, LSB first). It sits between the datapath output register and the board TX pin, replacing the bare outbox FIFO.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16 entries)
CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200); legal range >= 2

Ports:
clk  input  1  system clock
i_rst  input  1  asynchronous reset, active-high
wO  input  1  outbox write strobe from the control unit; one cycle per write
i_data  input  8  byte to enqueue, sampled when wO=1
outFull  output  1  FIFO full; the control unit must not assert wO while this is high
o_empty  output  1  FIFO empty
o_count  output  DEPTH_LOG2+1  current FIFO occupancy, 0..DEPTH
o_ovf  output  1  sticky flag: a write arrived while full; cleared only by reset
tx  output  1  UART serial out, idle high, registered
tx_busy  output  1  high while a frame is in flight (any state other than IDLE)

Behaviour:
- Reset (i_rst is asynchronous: outputs take these values immediately, with no clock edge):
  - tx=1, tx_busy=0, outFull=0, o_empty=1, o_count=0, o_ovf=0.
  - FIFO pointers 0, FSM in IDLE, bit counter and baud counter 0.
  - Reset mid-frame aborts the frame (tx returns high immediately) and flushes the FIFO.
- FIFO storage:
  - Circular buffer with read/write pointers of DEPTH_LOG2 bits that wrap modulo DEPTH.
  - Occupancy is held in a separate (DEPTH_LOG2+1)-bit counter.
  - outFull = (count==DEPTH) and o_empty = (count==0), both decoded from the registered count.
- Write:
  - When wO=1 and count<DEPTH at the rising edge, store i_data at wptr, increment wptr and count.
  - When wO=1 and count==DEPTH, discard the byte, leave pointers and count unchanged, and set o_ovf=1.
  - A pop in the same cycle does not rescue a write made while full: full is evaluated from the pre-edge count.
- Pop: occurs only on an FSM load edge (below). It reads mem[rptr] into the shift register and increments rptr.
- Simultaneous accepted write and pop: count is unchanged, both pointers advance.
- FSM states, with a baud counter bcnt (0..CLKS_PER_BIT-1) and bit index bidx (0..7):
  - IDLE: tx=1. If count>0 at the edge, pop, set bcnt=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bidx=0.
  - DATA: tx=shift[bidx] for CLKS_PER_BIT cycles each, LSB first. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last STOP cycle:
    - if count>0 (including a byte written that same cycle? no — evaluated pre-edge), pop and go directly to START, with no idle gap;
    - otherwise go to IDLE.
- tx is a registered output: it reflects the state/bit selected at the previous edge.
- Latency: with the FIFO empty and the FSM in IDLE, wO sampled at edge N gives:
  - count=1 after edge N;
  - pop and transition to START at edge N+1;
  - tx low from edge N+2.
- Frame length is exactly 10*CLKS_PER_BIT cycles from the tx falling edge to the end of the stop bit. Back-to-back frames are contiguous.
- tx_busy = (state != IDLE).
- o_count is never greater than DEPTH and never wraps below 0, since a pop only occurs when count>0.

Test Plan:
- Reset then idle 50 cycles -> tx=1, o_empty=1, outFull=0, o_count=0, tx_busy=0 throughout.
- CLKS_PER_BIT=4; single wO with i_data=0x41 -> tx low starting 2 cycles after the write edge. Line sequence: 0, then 1,0,0,0,0,0,1,0, then 1, each bit held 4 cycles; then tx_busy=0.
- CLKS_PER_BIT=4; three writes 0x00, 0xFF, 0x55 on consecutive cycles -> o_count peaks at 2 (the first is popped one cycle after its write). Three contiguous 40-cycle frames with no gap, bytes in order; o_empty=1 at the end.
- DEPTH_LOG2=2 (DEPTH=4), CLKS_PER_BIT=8; five writes on consecutive cycles 0x10..0x14 ->
  - 0x10 is popped one cycle after its write, so the remaining four bytes fill the FIFO;
  - outFull=1 while count==4;
  - if a sixth write 0x15 is issued while full: it is dropped, o_ovf=1 and stays 1;
  - transmitted bytes are 0x10..0x14, with no 0x15.
- Pointer wrap: DEPTH_LOG2=2; 10 writes, each issued only while outFull=0 -> all 10 bytes transmitted in order across wptr/rptr wraps; o_ovf stays 0.
- Assert i_rst asynchronously in the middle of DATA of the first of 3 queued frames -> tx=1 and o_count=0 immediately. After release, no further frames are sent until a new wO.
